// File: rtl/ofs_plat_prim_fifo_mc_pkg.sv
// rtl/ofs_plat_prim_fifo_mc_pkg.sv - shared helpers for the multi-channel LUTRAM FIFO
package ofs_plat_prim_fifo_mc_pkg;

    // Index increment that wraps at an arbitrary (not necessarily power-of-2) depth.
    function automatic int unsigned next_idx(input int unsigned idx, input int unsigned n_entries);
        return (idx + 32'd1 >= n_entries) ? 32'd0 : idx + 32'd1;
    endfunction

endpackage

// File: rtl/ofs_plat_prim_fifo_mc_chan.sv
// rtl/ofs_plat_prim_fifo_mc_chan.sv - one channel: LUTRAM store, pointers, count, flags, error, flush
module ofs_plat_prim_fifo_mc_chan
    import ofs_plat_prim_fifo_mc_pkg::*;
#(
    parameter int N_DATA_BITS     = 32,
    parameter int N_ENTRIES       = 4,
    parameter int THRESHOLD       = 1,
    parameter int REGISTER_OUTPUT = 0,
    parameter int CW              = $clog2(N_ENTRIES + 1)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   enq_en,
    input  logic                   bad_enq,
    input  logic [N_DATA_BITS-1:0] enq_data,
    input  logic                   deq_en,
    input  logic                   flush,
    output logic                   notFull,
    output logic                   almostFull,
    output logic [N_DATA_BITS-1:0] first,
    output logic                   notEmpty,
    output logic [CW-1:0]          count,
    output logic                   error
);

    localparam int IW = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1;

    logic [N_DATA_BITS-1:0] mem_q [N_ENTRIES];
    logic [IW-1:0]          wr_idx_q, wr_idx_d, rd_idx_q, rd_idx_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   error_q, error_d;
    logic                   notFull_q, almostFull_q, notEmpty_q, base_ne_q;
    logic                   enq_ok, deq_ok, err_set, pop;
    logic                   out_room, out_valid_d;

    // Registered flags are the only legality reference; a dequeue never makes room this cycle.
    assign enq_ok  = enq_en && notFull_q && !flush;
    assign deq_ok  = deq_en && notEmpty_q && !flush;
    assign err_set = !flush && ((enq_en && !notFull_q) || (deq_en && !notEmpty_q) || bad_enq);
    assign pop     = base_ne_q && out_room && !flush;

    assign error_d  = flush ? 1'b0 : (error_q || err_set);
    assign cnt_d    = flush ? '0 : (cnt_q + CW'(enq_ok) - CW'(pop));
    assign wr_idx_d = flush ? '0 : (enq_ok ? IW'(next_idx(32'(wr_idx_q), N_ENTRIES)) : wr_idx_q);
    assign rd_idx_d = flush ? '0 : (pop ? IW'(next_idx(32'(rd_idx_q), N_ENTRIES)) : rd_idx_q);

    always_ff @(posedge clk) begin
        if (enq_ok) begin
            mem_q[wr_idx_q] <= enq_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_idx_q     <= '0;
            rd_idx_q     <= '0;
            cnt_q        <= '0;
            error_q      <= 1'b0;
            notFull_q    <= 1'b0;
            almostFull_q <= 1'b1;
            notEmpty_q   <= 1'b0;
            base_ne_q    <= 1'b0;
        end else begin
            wr_idx_q     <= wr_idx_d;
            rd_idx_q     <= rd_idx_d;
            cnt_q        <= cnt_d;
            error_q      <= error_d;
            notFull_q    <= (cnt_d != CW'(N_ENTRIES)) && !error_d;
            almostFull_q <= (cnt_d >= CW'(N_ENTRIES - THRESHOLD)) || error_d;
            notEmpty_q   <= out_valid_d && !error_d;
            base_ne_q    <= (cnt_d != '0) && !error_d;
        end
    end

    generate
        if (REGISTER_OUTPUT != 0) begin : g_oreg
            logic                   ovalid_q;
            logic [N_DATA_BITS-1:0] oreg_q;

            // The stage refills whenever it is empty or its entry is being consumed.
            assign out_room    = !ovalid_q || deq_ok;
            assign out_valid_d = !flush && (pop || (ovalid_q && !deq_ok));
            assign first       = oreg_q;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    ovalid_q <= 1'b0;
                    oreg_q   <= '0;
                end else begin
                    ovalid_q <= out_valid_d;
                    if (pop) begin
                        oreg_q <= mem_q[rd_idx_q];
                    end
                end
            end
        end else begin : g_direct
            assign out_room    = deq_ok;
            assign out_valid_d = (cnt_d != '0);
            assign first       = mem_q[rd_idx_q];
        end
    endgenerate

    assign notFull    = notFull_q;
    assign almostFull = almostFull_q;
    assign notEmpty   = notEmpty_q;
    assign count      = cnt_q;
    assign error      = error_q;

endmodule

// File: rtl/ofs_plat_prim_fifo_lutram_mc.sv
// rtl/ofs_plat_prim_fifo_lutram_mc.sv - N independent LUTRAM FIFOs behind one shared enqueue port
module ofs_plat_prim_fifo_lutram_mc
    import ofs_plat_prim_fifo_mc_pkg::*;
#(
    parameter int N_DATA_BITS     = 32,
    parameter int N_ENTRIES       = 4,
    parameter int N_CHANNELS      = 2,
    parameter int THRESHOLD       = 1,
    parameter int REGISTER_OUTPUT = 0,
    parameter int CHW             = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1,
    parameter int CW              = $clog2(N_ENTRIES + 1)
) (
    input  logic                                  clk,
    input  logic                                  reset_n,
    input  logic [N_DATA_BITS-1:0]                enq_data,
    input  logic [CHW-1:0]                        enq_chan,
    input  logic                                  enq_en,
    output logic [N_CHANNELS-1:0]                 notFull,
    output logic [N_CHANNELS-1:0]                 almostFull,
    output logic [N_CHANNELS-1:0][N_DATA_BITS-1:0] first,
    input  logic [N_CHANNELS-1:0]                 deq_en,
    output logic [N_CHANNELS-1:0]                 notEmpty,
    output logic [N_CHANNELS-1:0][CW-1:0]         count,
    input  logic [N_CHANNELS-1:0]                 flush,
    output logic [N_CHANNELS-1:0]                 error
);

    logic [CHW:0] chan_ext;
    logic         bad_enq;

    // Out-of-range channel selects are reported on the last channel.
    assign chan_ext = {1'b0, enq_chan};
    assign bad_enq  = enq_en && (32'(chan_ext) >= N_CHANNELS);

    for (genvar c = 0; c < N_CHANNELS; c++) begin : g_chan
        ofs_plat_prim_fifo_mc_chan #(
            .N_DATA_BITS     (N_DATA_BITS),
            .N_ENTRIES       (N_ENTRIES),
            .THRESHOLD       (THRESHOLD),
            .REGISTER_OUTPUT (REGISTER_OUTPUT),
            .CW              (CW)
        ) u_chan (
            .clk        (clk),
            .reset_n    (reset_n),
            .enq_en     (enq_en && (enq_chan == CHW'(c))),
            .bad_enq    ((c == N_CHANNELS - 1) ? bad_enq : 1'b0),
            .enq_data   (enq_data),
            .deq_en     (deq_en[c]),
            .flush      (flush[c]),
            .notFull    (notFull[c]),
            .almostFull (almostFull[c]),
            .first      (first[c]),
            .notEmpty   (notEmpty[c]),
            .count      (count[c]),
            .error      (error[c])
        );
    end

endmodule

// File: tb/tb_ofs_plat_prim_fifo_lutram_mc.sv
// tb/tb_ofs_plat_prim_fifo_lutram_mc.sv - self-checking bench for the multi-channel LUTRAM FIFO
module tb_ofs_plat_prim_fifo_lutram_mc;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // DUT A: defaults (4 entries, 2 channels, THRESHOLD 1, direct output)
    logic [31:0]      a_data;
    logic [0:0]       a_chan;
    logic             a_en;
    logic [1:0]       a_deq, a_flush, a_nf, a_af, a_ne, a_err;
    logic [1:0][31:0] a_first;
    logic [1:0][2:0]  a_count;

    // DUT B: 3 entries, 3 channels
    logic [31:0]      b_data;
    logic [1:0]       b_chan;
    logic             b_en;
    logic [2:0]       b_deq, b_flush, b_nf, b_af, b_ne, b_err;
    logic [2:0][31:0] b_first;
    logic [2:0][1:0]  b_count;

    // DUT C: registered output
    logic [31:0]      c_data;
    logic [0:0]       c_chan;
    logic             c_en;
    logic [1:0]       c_deq, c_flush, c_nf, c_af, c_ne, c_err;
    logic [1:0][31:0] c_first;
    logic [1:0][2:0]  c_count;

    ofs_plat_prim_fifo_lutram_mc u_a (
        .clk(clk), .reset_n(reset_n), .enq_data(a_data), .enq_chan(a_chan), .enq_en(a_en),
        .notFull(a_nf), .almostFull(a_af), .first(a_first), .deq_en(a_deq), .notEmpty(a_ne),
        .count(a_count), .flush(a_flush), .error(a_err));

    ofs_plat_prim_fifo_lutram_mc #(.N_ENTRIES(3), .N_CHANNELS(3)) u_b (
        .clk(clk), .reset_n(reset_n), .enq_data(b_data), .enq_chan(b_chan), .enq_en(b_en),
        .notFull(b_nf), .almostFull(b_af), .first(b_first), .deq_en(b_deq), .notEmpty(b_ne),
        .count(b_count), .flush(b_flush), .error(b_err));

    ofs_plat_prim_fifo_lutram_mc #(.REGISTER_OUTPUT(1)) u_c (
        .clk(clk), .reset_n(reset_n), .enq_data(c_data), .enq_chan(c_chan), .enq_en(c_en),
        .notFull(c_nf), .almostFull(c_af), .first(c_first), .deq_en(c_deq), .notEmpty(c_ne),
        .count(c_count), .flush(c_flush), .error(c_err));

    typedef struct {
        logic        en;
        logic        ch;
        logic [31:0] d;
        logic [1:0]  deq, fl;
        logic [1:0]  nf, af, ne, err;
        logic [2:0]  c0, c1;
        logic [31:0] f0, f1;
    } vec_t;

    vec_t        tbl[17];
    logic [31:0] mq0[$];
    logic [31:0] mq1[$];
    logic [31:0] bq[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        a_en = 0; a_deq = 0; a_flush = 0; a_chan = 0; a_data = 0;
        b_en = 0; b_deq = 0; b_flush = 0; b_chan = 0; b_data = 0;
        c_en = 0; c_deq = 0; c_flush = 0; c_chan = 0; c_data = 0;
    endtask

    task automatic chk_a_reset(input string tag);
        chk({tag, "_nf"},  64'(a_nf),  64'h0);
        chk({tag, "_af"},  64'(a_af),  64'h3);
        chk({tag, "_ne"},  64'(a_ne),  64'h0);
        chk({tag, "_cnt"}, 64'(a_count), 64'h0);
        chk({tag, "_err"}, 64'(a_err), 64'h0);
    endtask

    task automatic chk_a_idle(input string tag);
        chk({tag, "_nf"},  64'(a_nf),  64'h3);
        chk({tag, "_af"},  64'(a_af),  64'h0);
        chk({tag, "_ne"},  64'(a_ne),  64'h0);
        chk({tag, "_cnt"}, 64'(a_count), 64'h0);
    endtask

    // Model view: a channel is full at 4 entries, almost full at 3 or more.
    task automatic chk_a_model(input int c, input int sz, input logic [31:0] head);
        chk($sformatf("rand_nf%0d", c),  64'(a_nf[c]),    64'(sz < 4));
        chk($sformatf("rand_af%0d", c),  64'(a_af[c]),    64'(sz >= 3));
        chk($sformatf("rand_ne%0d", c),  64'(a_ne[c]),    64'(sz > 0));
        chk($sformatf("rand_cnt%0d", c), 64'(a_count[c]), 64'(sz));
        chk($sformatf("rand_err%0d", c), 64'(a_err[c]),   64'h0);
        if (sz > 0) chk($sformatf("rand_first%0d", c), 64'(a_first[c]), 64'(head));
    endtask

    initial begin
        idle_all();
        tbl[0]  = '{1, 1, 32'hA0, 2'b00, 2'b00, 2'b11, 2'b00, 2'b10, 2'b00, 0, 1, 0, 32'hA0};
        tbl[1]  = '{1, 1, 32'hA1, 2'b00, 2'b00, 2'b11, 2'b00, 2'b10, 2'b00, 0, 2, 0, 32'hA0};
        tbl[2]  = '{1, 1, 32'hA2, 2'b00, 2'b00, 2'b11, 2'b10, 2'b10, 2'b00, 0, 3, 0, 32'hA0};
        tbl[3]  = '{1, 1, 32'hA3, 2'b00, 2'b00, 2'b01, 2'b10, 2'b10, 2'b00, 0, 4, 0, 32'hA0};
        tbl[4]  = '{0, 1, 32'h00, 2'b10, 2'b00, 2'b11, 2'b10, 2'b10, 2'b00, 0, 3, 0, 32'hA1};
        tbl[5]  = '{0, 1, 32'h00, 2'b10, 2'b00, 2'b11, 2'b00, 2'b10, 2'b00, 0, 2, 0, 32'hA2};
        tbl[6]  = '{0, 1, 32'h00, 2'b10, 2'b00, 2'b11, 2'b00, 2'b10, 2'b00, 0, 1, 0, 32'hA3};
        tbl[7]  = '{0, 1, 32'h00, 2'b10, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 0, 0, 0, 32'h00};
        tbl[8]  = '{1, 0, 32'h44, 2'b00, 2'b00, 2'b11, 2'b00, 2'b01, 2'b00, 1, 0, 32'h44, 0};
        tbl[9]  = '{1, 0, 32'h55, 2'b01, 2'b00, 2'b11, 2'b00, 2'b01, 2'b00, 1, 0, 32'h55, 0};
        tbl[10] = '{1, 0, 32'hC1, 2'b00, 2'b00, 2'b11, 2'b00, 2'b01, 2'b00, 2, 0, 32'h55, 0};
        tbl[11] = '{1, 0, 32'hC2, 2'b00, 2'b00, 2'b11, 2'b01, 2'b01, 2'b00, 3, 0, 32'h55, 0};
        tbl[12] = '{1, 0, 32'hC3, 2'b00, 2'b00, 2'b10, 2'b01, 2'b01, 2'b00, 4, 0, 32'h55, 0};
        tbl[13] = '{1, 0, 32'hDD, 2'b00, 2'b00, 2'b10, 2'b01, 2'b00, 2'b01, 4, 0, 0, 0};
        tbl[14] = '{0, 0, 32'h00, 2'b00, 2'b01, 2'b11, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0};
        tbl[15] = '{0, 0, 32'h00, 2'b10, 2'b00, 2'b01, 2'b10, 2'b00, 2'b10, 0, 0, 0, 0};
        tbl[16] = '{1, 1, 32'hEE, 2'b00, 2'b10, 2'b11, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0};

        // Asynchronous reset asserted between clock edges
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b0;
        #1 chk_a_reset("rst_async");
        tick();
        chk_a_reset("rst_held");
        reset_n = 1'b1;
        tick();
        chk_a_idle("bringup");
        chk("bringup_err", 64'(a_err), 64'h0);

        for (int i = 0; i < 17; i++) begin
            a_en = tbl[i].en; a_chan = tbl[i].ch; a_data = tbl[i].d;
            a_deq = tbl[i].deq; a_flush = tbl[i].fl;
            tick();
            idle_all();
            chk($sformatf("v%0d_nf", i),  64'(a_nf),  64'(tbl[i].nf));
            chk($sformatf("v%0d_af", i),  64'(a_af),  64'(tbl[i].af));
            chk($sformatf("v%0d_ne", i),  64'(a_ne),  64'(tbl[i].ne));
            chk($sformatf("v%0d_err", i), 64'(a_err), 64'(tbl[i].err));
            chk($sformatf("v%0d_c0", i),  64'(a_count[0]), 64'(tbl[i].c0));
            chk($sformatf("v%0d_c1", i),  64'(a_count[1]), 64'(tbl[i].c1));
            if (tbl[i].ne[0]) chk($sformatf("v%0d_f0", i), 64'(a_first[0]), 64'(tbl[i].f0));
            if (tbl[i].ne[1]) chk($sformatf("v%0d_f1", i), 64'(a_first[1]), 64'(tbl[i].f1));
        end

        // Random legal traffic with occasional flushes against queue model
        for (int t = 0; t < 400; t++) begin
            int c;
            a_deq = 0; a_en = 0; a_flush = 0;
            if (mq0.size() > 0 && $urandom_range(1, 0) == 1) a_deq[0] = 1'b1;
            if (mq1.size() > 0 && $urandom_range(1, 0) == 1) a_deq[1] = 1'b1;
            c = int'($urandom_range(1, 0));
            if ($urandom_range(3, 0) != 0 && ((c == 0) ? mq0.size() : mq1.size()) < 4) begin
                a_en = 1'b1; a_chan = 1'(c); a_data = $urandom;
            end
            if ($urandom_range(31, 0) == 0) a_flush[$urandom_range(1, 0)] = 1'b1;
            if (a_flush[0]) mq0.delete();
            else begin
                if (a_deq[0]) void'(mq0.pop_front());
                if (a_en && a_chan == 0) mq0.push_back(a_data);
            end
            if (a_flush[1]) mq1.delete();
            else begin
                if (a_deq[1]) void'(mq1.pop_front());
                if (a_en && a_chan == 1) mq1.push_back(a_data);
            end
            tick();
            idle_all();
            chk_a_model(0, mq0.size(), (mq0.size() > 0) ? mq0[0] : 32'h0);
            chk_a_model(1, mq1.size(), (mq1.size() > 0) ? mq1[0] : 32'h0);
        end

        // Non-power-of-2 depth wrap on DUT B channel 0
        for (int i = 0; i < 10; i++) begin
            b_en = 1'b1; b_chan = 2'd0; b_data = 32'h30 + 32'(i);
            b_deq = (bq.size() >= 2) ? 3'b001 : 3'b000;
            if (b_deq[0]) void'(bq.pop_front());
            bq.push_back(b_data);
            tick();
            idle_all();
            chk($sformatf("wrap_cnt%0d", i),   64'(b_count[0]), 64'(bq.size()));
            chk($sformatf("wrap_first%0d", i), 64'(b_first[0]), 64'(bq[0]));
        end
        b_en = 1'b1; b_chan = 2'd3; b_data = 32'hBAD;
        tick();
        idle_all();
        chk("badchan_err", 64'(b_err), 64'h4);
        chk("badchan_nf2", 64'(b_nf[2]), 64'h0);
        chk("badchan_cnt0", 64'(b_count[0]), 64'(bq.size()));

        // Registered output: two-cycle visibility, count excludes the stage
        c_en = 1'b1; c_chan = 1'b0; c_data = 32'h11;
        tick();
        idle_all();
        chk("ro_t1_ne", 64'(c_ne[0]), 64'h0);
        chk("ro_t1_cnt", 64'(c_count[0]), 64'h1);
        tick();
        chk("ro_t2_ne", 64'(c_ne[0]), 64'h1);
        chk("ro_t2_first", 64'(c_first[0]), 64'h11);
        chk("ro_t2_cnt", 64'(c_count[0]), 64'h0);
        c_deq = 2'b01; c_en = 1'b1; c_chan = 1'b0; c_data = 32'h22;
        tick();
        idle_all();
        chk("ro_t3_ne", 64'(c_ne[0]), 64'h0);
        chk("ro_t3_cnt", 64'(c_count[0]), 64'h1);
        tick();
        chk("ro_t4_ne", 64'(c_ne[0]), 64'h1);
        chk("ro_t4_first", 64'(c_first[0]), 64'h22);
        chk("ro_t4_err", 64'(c_err), 64'h0);

        // Reset while DUT A holds data
        a_en = 1'b1; a_chan = 1'b0; a_data = 32'h77;
        tick();
        a_chan = 1'b1;
        tick();
        idle_all();
        @(posedge clk);
        #3 reset_n = 1'b0;
        #1 chk_a_reset("rst_midop");
        tick();
        reset_n = 1'b1;
        tick();
        chk_a_idle("rst_release");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
